// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - lane select and sign/zero extension of a loaded word
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    data     = '0;
    case (size)
      SIZE_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word access on a word-only memory
// Sub-word stores become a registered read-modify-write over two cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] StoreData,
  output logic [DATA_W-1:0] LoadData,
  output logic              Stall,
  output logic              Fault,
  output logic              FaultFlag,
  input  logic              ClearFault,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWE,
  input  logic [DATA_W-1:0] MemReadData
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [ADDR_W-1:0] addr_q;
  logic              fault_flag_q;
  logic              misalign;
  logic              sub_store;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] extract_data;

  assign word_addr = {Address[ADDR_W-1:2], 2'b00};

  always_comb begin
    misalign = 1'b0;
    case (Size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = Address[0];
      SIZE_WORD: misalign = |Address[1:0];
      default:   misalign = 1'b1;
    endcase
  end

  // Faults are only meaningful for a request presented in IDLE.
  assign Fault = (state_q == IDLE) && (MemRead || MemWrite) &&
                 (misalign || (MemRead && MemWrite));

  assign sub_store = (state_q == IDLE) && MemWrite && !Fault &&
                     ((Size == SIZE_BYTE) || (Size == SIZE_HALF));

  always_comb begin
    merge_d = MemReadData;
    if (Size == SIZE_BYTE)
      merge_d[{Address[1:0], 3'b000} +: 8] = StoreData[7:0];
    else
      merge_d[{Address[1], 4'b0000} +: 16] = StoreData[15:0];
  end

  load_extract u_load_extract (
    .word     (MemReadData),
    .offset   (Address[1:0]),
    .size     (Size),
    .sign_ext (SignExt),
    .data     (extract_data)
  );

  assign LoadData  = Fault ? '0 : extract_data;
  assign FaultFlag = fault_flag_q;

  always_comb begin
    state_d      = state_q;
    MemAddress   = word_addr;
    MemWriteData = StoreData;
    MemWE        = 1'b0;
    Stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sub_store) begin
          Stall   = 1'b1;
          state_d = RMW_WR;
        end else if (MemWrite && !Fault) begin
          MemWE = 1'b1;
        end
      end
      RMW_WR: begin
        MemAddress   = addr_q;
        MemWriteData = merge_q;
        MemWE        = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence memory immediately, not at the next edge.
    if (!RESETn) begin
      MemWE = 1'b0;
      Stall = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      addr_q       <= '0;
      fault_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sub_store) begin
        merge_q <= merge_d;
        addr_q  <= word_addr;
      end
      if (Fault)
        fault_flag_q <= 1'b1;
      else if (ClearFault)
        fault_flag_q <= 1'b0;
    end
  end

endmodule
